// File: rtl/interrupt_controller.sv
// IF/IE/IME interrupt controller feeding the ControlUnit: pending vector, delayed-EI sequencing, priority dispatch.
// Optional INTC_EDGE_DETECT_EN: requests are levels and IF sets only on a rising edge of each line.
module interrupt_controller #(
  parameter int         NUM_SRC     = 5,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic [NUM_SRC-1:0] i_Request,
  input  logic [15:0]        i_Addr,
  input  logic [7:0]         i_Data,
  input  logic               i_Write,
  input  logic               i_Read,
  output logic [7:0]         o_Data,
  output logic               o_Data_Valid,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Instr_End,
  input  logic               i_Ack,
  output logic [NUM_SRC-1:0] o_Pending,
  output logic               o_Irq,
  output logic [7:0]         o_Vector,
  output logic               o_IME
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {EI_IDLE, EI_ARMED, EI_WAIT} ei_state_e;

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [7:0]         vec_q, vec_d;
  logic               ime_q, ime_d;
  ei_state_e          ei_q, ei_d;
  logic [NUM_SRC-1:0] pend, set_mask;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic               sel_if, sel_ie;
  logic [7:0]         if_rd;

  function automatic logic [7:0] src_vector(input logic [IDX_W-1:0] n);
    return VECTOR_BASE + (8'(n) << 3);
  endfunction

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] req_prev_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst)         req_prev_q <= '0;
    else if (i_Enable) req_prev_q <= i_Request;
  end

  assign set_mask = i_Request & ~req_prev_q;
`else
  assign set_mask = i_Request;
`endif

  assign pend   = if_q & ie_q[NUM_SRC-1:0];
  assign sel_if = (i_Addr == 16'hFF0F);
  assign sel_ie = (i_Addr == 16'hFFFF);

  // Lowest set pending bit wins; scan downward so the last hit is the lowest index.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win     = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    if_rd                = '1;
    if_rd[NUM_SRC-1:0]   = if_q;
    o_Data               = 8'h00;
    if (i_Read && sel_if)      o_Data = if_rd;
    else if (i_Read && sel_ie) o_Data = ie_q;
  end

  assign o_Data_Valid = i_Read & (sel_if | sel_ie);

  // Write, then ack clear, then request set: a new request always survives.
  always_comb begin
    if_d  = if_q;
    ie_d  = ie_q;
    vec_d = vec_q;
    if (i_Write && sel_if) if_d = i_Data[NUM_SRC-1:0];
    if (i_Write && sel_ie) ie_d = i_Data;
    if (i_Ack) begin
      vec_d = win_vld ? src_vector(win) : 8'h00;
      if (win_vld) if_d[win] = 1'b0;
    end
    if_d = if_d | set_mask;
  end

  always_comb begin
    ime_d = ime_q;
    ei_d  = ei_q;
    if (i_DI || i_Ack) begin
      ime_d = 1'b0;
      ei_d  = EI_IDLE;
    end else if (i_RETI) begin
      ime_d = 1'b1;
      ei_d  = EI_IDLE;
    end else if (i_EI) begin
      ei_d = EI_ARMED;
    end else if (i_Instr_End) begin
      case (ei_q)
        EI_ARMED: ei_d = EI_WAIT;
        EI_WAIT: begin
          ei_d  = EI_IDLE;
          ime_d = 1'b1;
        end
        default: ei_d = EI_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      if_q  <= '0;
      ie_q  <= 8'h00;
      vec_q <= 8'h00;
      ime_q <= 1'b0;
      ei_q  <= EI_IDLE;
    end else if (i_Enable) begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      vec_q <= vec_d;
      ime_q <= ime_d;
      ei_q  <= ei_d;
    end
  end

  assign o_Pending = pend;
  assign o_Irq     = ime_q & (|pend);
  assign o_Vector  = vec_q;
  assign o_IME     = ime_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: directed scenarios with fixed expectations, then random traffic vs. a reference model.
module tb_interrupt_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [4:0] req = '0;
  logic [15:0] addr = 16'h0000;
  logic [7:0] wdata = 8'h00;
  logic       wr = 1'b0, rd = 1'b0;
  logic       ei = 1'b0, di = 1'b0, reti = 1'b0, iend = 1'b0, ack = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [4:0] pending;
  logic       irq, ime;
  logic [7:0] vector;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [4:0] pend;
    logic       irq;
    logic       ime;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: IME becomes 1 when ei_left counts down to zero on instruction ends.
  logic [4:0] m_if = '0, m_prev = '0;
  logic [7:0] m_ie = '0, m_vec = '0;
  logic       m_ime = 1'b0;
  int         m_ei_left = 0;

  interrupt_controller dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Request(req),
    .i_Addr(addr), .i_Data(wdata), .i_Write(wr), .i_Read(rd),
    .o_Data(rdata), .o_Data_Valid(rvalid),
    .i_EI(ei), .i_DI(di), .i_RETI(reti), .i_Instr_End(iend), .i_Ack(ack),
    .o_Pending(pending), .o_Irq(irq), .o_Vector(vector), .o_IME(ime)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [4:0] pend, setm, nif;
    int n;
    if (rst) begin
      m_if = '0; m_ie = '0; m_vec = '0; m_ime = 0; m_ei_left = 0; m_prev = '0;
    end else if (en) begin
      pend = m_if & m_ie[4:0];
      n = lowest(pend);
`ifdef INTC_EDGE_DETECT_EN
      setm = req & ~m_prev;
`else
      setm = req;
`endif
      nif = m_if;
      if (wr && addr == 16'hFF0F) nif = wdata[4:0];
      if (ack) begin
        if (n >= 0) begin
          m_vec = 8'h40 + 8'(8 * n);
          nif[n] = 1'b0;
        end else m_vec = 8'h00;
      end
      m_if = nif | setm;
      if (wr && addr == 16'hFFFF) m_ie = wdata;
      if (di || ack) begin m_ime = 0; m_ei_left = 0; end
      else if (reti) begin m_ime = 1; m_ei_left = 0; end
      else if (ei) m_ei_left = 2;
      else if (iend && m_ei_left > 0) begin
        m_ei_left--;
        if (m_ei_left == 0) m_ime = 1;
      end
      m_prev = req;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; wr = 0; rd = 0; ei = 0; di = 0; reti = 0; iend = 0; ack = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] d,
                        input logic [4:0] p, input logic q, input logic im, input logic [7:0] v);
    exp_t e;
    e.name = nm; e.data = d; e.pend = p; e.irq = q; e.ime = im; e.vec = v;
    exp_q.push_back(e);
    rd = 1; addr = a;
    step();
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    wr = 1; addr = a; wdata = d;
    step();
  endtask

  task automatic pulse_req(input logic [4:0] v);
    req = v;
    step();
    req = '0;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Monitor: every valid read pops one expectation and checks all observable outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: got valid read of %h, expected none", addr);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, ".data"}, rdata, e.data);
        chk({e.name, ".pend"}, {3'b0, pending}, {3'b0, e.pend});
        chk({e.name, ".irq"},  {7'b0, irq}, {7'b0, e.irq});
        chk({e.name, ".ime"},  {7'b0, ime}, {7'b0, e.ime});
        chk({e.name, ".vec"},  vector, e.vec);
      end
    end else if (rd) begin
      chk("unselected_data", rdata, 8'h00);
    end
  end

  initial begin
    exp_t e;
    logic [15:0] ra;
    #1;
    rst = 1; step();
    rd_chk("reset_if", 16'hFF0F, 8'hE0, 5'h00, 0, 0, 8'h00);
    rd_chk("reset_ie", 16'hFFFF, 8'h00, 5'h00, 0, 0, 8'h00);

    write(16'hFFFF, 8'h05);
    pulse_req(5'b00100);
    rd_chk("timer_pend_ime0", 16'hFF0F, 8'hE4, 5'b00100, 0, 0, 8'h00);
    reti = 1; step();
    rd_chk("reti_irq", 16'hFF0F, 8'hE4, 5'b00100, 1, 1, 8'h00);

    write(16'hFF0F, 8'h00);
    write(16'hFFFF, 8'h1F);
    pulse_req(5'b10110);
    rd_chk("multi_pend", 16'hFF0F, 8'hF6, 5'b10110, 1, 1, 8'h00);
    ack = 1; step();
    rd_chk("ack_stat", 16'hFF0F, 8'hF4, 5'b10100, 0, 0, 8'h48);
    reti = 1; step();
    ack = 1; step();
    rd_chk("ack_timer", 16'hFF0F, 8'hF0, 5'b10000, 0, 0, 8'h50);
    reti = 1; step();
    ack = 1; step();
    rd_chk("ack_joypad", 16'hFF0F, 8'hE0, 5'b00000, 0, 0, 8'h60);

    ei = 1; step();
    iend = 1; step();
    rd_chk("ei_first_end", 16'hFFFF, 8'h1F, 5'h00, 0, 0, 8'h60);
    iend = 1; step();
    rd_chk("ei_second_end", 16'hFFFF, 8'h1F, 5'h00, 0, 1, 8'h60);
    di = 1; step();
    ei = 1; step();
    iend = 1; step();
    di = 1; step();
    iend = 1; step();
    rd_chk("ei_di_cancel", 16'hFFFF, 8'h1F, 5'h00, 0, 0, 8'h60);
    iend = 1; step();
    rd_chk("ei_di_cancel2", 16'hFFFF, 8'h1F, 5'h00, 0, 0, 8'h60);
    ei = 1; di = 1; step();
    iend = 1; step();
    iend = 1; step();
    rd_chk("di_beats_ei", 16'hFFFF, 8'h1F, 5'h00, 0, 0, 8'h60);

    write(16'hFFFF, 8'h01);
    pulse_req(5'b00001);
    reti = 1; step();
    write(16'hFF0F, 8'h00);
    ack = 1; step();
    rd_chk("withdrawn_ack", 16'hFF0F, 8'hE0, 5'h00, 0, 0, 8'h00);

    wr = 1; addr = 16'hFF0F; wdata = 8'h00; req = 5'b00001; step();
    req = '0;
    rd_chk("write_vs_req", 16'hFF0F, 8'hE1, 5'b00001, 0, 0, 8'h00);

`ifdef INTC_EDGE_DETECT_EN
    write(16'hFF0F, 8'h00);
    req = 5'b01000; step();
    rd_chk("edge_set", 16'hFF0F, 8'hE8, 5'h00, 0, 0, 8'h00);
    wr = 1; addr = 16'hFF0F; wdata = 8'h00; step();
    for (int i = 0; i < 6; i++) rd_chk("edge_held", 16'hFF0F, 8'hE0, 5'h00, 0, 0, 8'h00);
    req = '0; step();
    rd_chk("edge_dropped", 16'hFF0F, 8'hE0, 5'h00, 0, 0, 8'h00);
    req = 5'b01000; step();
    req = '0;
    rd_chk("edge_rerise", 16'hFF0F, 8'hE8, 5'h00, 0, 0, 8'h00);
`endif

    rst = 1; step();
    for (int c = 0; c < 1500; c++) begin
      en   = ($urandom_range(7) != 0);
      rst  = ($urandom_range(199) == 0);
      req  = '0;
      for (int b = 0; b < 5; b++) req[b] = ($urandom_range(5) == 0);
      wr   = ($urandom_range(7) == 0);
      ra   = ($urandom_range(2) == 0) ? 16'hFF10 : (($urandom_range(1) == 0) ? 16'hFF0F : 16'hFFFF);
      addr = ra;
      wdata = 8'($urandom);
      ack  = ($urandom_range(9) == 0);
      ei   = ($urandom_range(11) == 0);
      di   = ($urandom_range(19) == 0);
      reti = ($urandom_range(15) == 0);
      iend = ($urandom_range(3) == 0);
      rd   = ($urandom_range(1) == 0);
      if (rd && ra != 16'hFF10) begin
        e.name = "random";
        e.data = (ra == 16'hFF0F) ? {3'b111, m_if} : m_ie;
        e.pend = m_if & m_ie[4:0];
        e.irq  = m_ime & (|(m_if & m_ie[4:0]));
        e.ime  = m_ime;
        e.vec  = m_vec;
        exp_q.push_back(e);
      end
      step();
    end
    en = 1; req = '0;
    step();
    step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d unmatched expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
